// File: rtl/prbs_ber_ctrl.sv
// PRBS bit-error-rate sequencer: baud tick generation, latency search over a
// reference delay line, then bit/error counting for a programmed symbol count.
module prbs_ber_ctrl #(
    parameter int BAUD_DIV = 4,
    parameter int SYNC_WIN = 16,
    parameter int DLY_W    = 3,
    parameter int NSYM_W   = 16,
    parameter int ERR_W    = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [NSYM_W-1:0] i_n_symbols,
    input  logic              i_ref_bit,
    input  logic              i_rx_bit,
    output logic              o_enable,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_sync_ok,
    output logic [DLY_W-1:0]  o_delay,
    output logic [NSYM_W-1:0] o_bit_count,
    output logic [ERR_W-1:0]  o_err_count
);

    localparam int LINE_W = (1 << DLY_W) - 1;
    localparam int DIV_W  = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam int WIN_W  = $clog2(SYNC_WIN + 1);
    localparam logic [DLY_W-1:0] D_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_SYNC, S_RUN, S_DONE} state_t;

    state_t              state, state_nx;
    logic [DIV_W-1:0]    div_cnt;
    logic [LINE_W-1:0]   dline;
    logic [DLY_W-1:0]    cand_d;
    logic [WIN_W-1:0]    win_cnt;
    logic                err_flag;
    logic [NSYM_W-1:0]   n_lat;
    logic                accept, active, active_nx, dref, mism, flag_nx, win_last;
    logic [NSYM_W-1:0]   bit_inc;

    assign accept    = ((state == S_IDLE) || (state == S_DONE)) && i_start;
    assign active    = (state == S_SYNC) || (state == S_RUN);
    assign active_nx = (state_nx == S_SYNC) || (state_nx == S_RUN);
    assign o_enable  = active && (div_cnt == DIV_W'(BAUD_DIV - 1));
    assign o_busy    = active;
    assign o_done    = (state == S_DONE);
    assign win_last  = (win_cnt == WIN_W'(SYNC_WIN - 1));
    assign bit_inc   = o_bit_count + 1'b1;

    // Candidate 0 is the undelayed reference; line[0] holds the newest bit.
    always_comb begin
        dref = i_ref_bit;
        if (cand_d != '0) dref = dline[cand_d - 1'b1];
    end

    assign mism    = o_enable && (i_rx_bit ^ dref);
    assign flag_nx = err_flag | mism;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= S_IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: if (i_start) state_nx = S_SYNC;
            S_SYNC: begin
                if (o_enable && win_last) begin
                    if (!flag_nx)             state_nx = S_RUN;
                    else if (cand_d == D_MAX) state_nx = S_DONE;
                end
            end
            S_RUN: begin
                if (n_lat == '0)                         state_nx = S_DONE;
                else if (o_enable && (bit_inc == n_lat)) state_nx = S_DONE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            div_cnt     <= '0;
            dline       <= '0;
            cand_d      <= '0;
            win_cnt     <= '0;
            err_flag    <= 1'b0;
            n_lat       <= '0;
            o_sync_ok   <= 1'b0;
            o_delay     <= '0;
            o_bit_count <= '0;
            o_err_count <= '0;
        end else if (accept) begin
            div_cnt     <= '0;
            cand_d      <= '0;
            win_cnt     <= '0;
            err_flag    <= 1'b0;
            n_lat       <= i_n_symbols;
            o_sync_ok   <= 1'b0;
            o_delay     <= '0;
            o_bit_count <= '0;
            o_err_count <= '0;
        end else begin
            // The divider parks at 0 whenever the next state is not counting.
            if (!active_nx || o_enable) div_cnt <= '0;
            else                        div_cnt <= div_cnt + 1'b1;

            if (o_enable) dline <= LINE_W'({dline, i_ref_bit});

            if (state == S_SYNC && o_enable) begin
                if (win_last) begin
                    if (!flag_nx) begin
                        o_sync_ok <= 1'b1;
                        o_delay   <= cand_d;
                    end else if (cand_d != D_MAX) begin
                        cand_d   <= cand_d + 1'b1;
                        win_cnt  <= '0;
                        err_flag <= 1'b0;
                    end
                end else begin
                    win_cnt  <= win_cnt + 1'b1;
                    err_flag <= flag_nx;
                end
            end

            if (state == S_RUN && o_enable && n_lat != '0) begin
                o_bit_count <= bit_inc;
                if (mism && o_err_count != '1) o_err_count <= o_err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prbs_ber_ctrl.sv
// Bench for prbs_ber_ctrl: PRBS9 reference stream, programmable channel delay,
// expected results queued per start and checked when o_done rises.
module tb_prbs_ber_ctrl;

    localparam int NS = 16;

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_start = 1'b0;
    logic [NS-1:0] i_n_symbols = '0;
    logic          i_ref_bit, i_rx_bit;
    logic          o_enable, o_busy, o_done, o_sync_ok;
    logic [2:0]    o_delay;
    logic [NS-1:0] o_bit_count;
    logic [NS-1:0] o_err_count;

    prbs_ber_ctrl dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
        .i_n_symbols(i_n_symbols), .i_ref_bit(i_ref_bit), .i_rx_bit(i_rx_bit),
        .o_enable(o_enable), .o_busy(o_busy), .o_done(o_done),
        .o_sync_ok(o_sync_ok), .o_delay(o_delay),
        .o_bit_count(o_bit_count), .o_err_count(o_err_count)
    );

    always #5 i_clk = ~i_clk;

    int  checks = 0;
    int  fails  = 0;
    bit  ref_seq [0:8191];
    int  tick_idx = 0;
    logic en_q = 1'b0;
    logic done_prev = 1'b0;

    // Channel model: rx is the reference delayed cur_d symbols, optionally
    // inverted, with up to two single-symbol flips at chosen tick indices.
    int  cur_d = 0;
    bit  cur_inv = 1'b0;
    bit  flip_en = 1'b0;
    int  flip_a = -1;
    int  flip_b = -1;

    // {sync_ok, delay[2:0], bits[15:0], errs[15:0], end_tick[15:0]}
    logic [51:0] exp_q[$];

    assign i_ref_bit = ref_seq[tick_idx];
    assign i_rx_bit  = ((tick_idx >= cur_d) ? ref_seq[tick_idx - cur_d] : 1'b0)
                       ^ cur_inv ^ (flip_en && (tick_idx == flip_a || tick_idx == flip_b));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit ref_at(input int k, input int d);
        return (k - d >= 0) ? ref_seq[k - d] : 1'b0;
    endfunction

    function automatic bit rx_at(input int k, input bit use_flips);
        bit b;
        b = ref_at(k, cur_d) ^ cur_inv;
        if (use_flips && flip_en && (k == flip_a || k == flip_b)) b = ~b;
        return b;
    endfunction

    always @(posedge i_clk) en_q <= o_enable;

    // Monitor: tick accounting and scoreboard compare on each rising o_done.
    always @(negedge i_clk) begin
        logic [51:0] e;
        if (i_reset) begin
            tick_idx  = 0;
            done_prev = 1'b0;
        end else begin
            if (en_q) tick_idx = tick_idx + 1;
            if (o_done && !done_prev) begin
                if (exp_q.size() == 0) chk("done_unexpected", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("sync_ok",   int'(o_sync_ok),   int'(e[51]));
                    chk("delay",     int'(o_delay),     int'(e[50:48]));
                    chk("bit_count", int'(o_bit_count), int'(e[47:32]));
                    chk("err_count", int'(o_err_count), int'(e[31:16]));
                    chk("tick_span", tick_idx,          int'(e[15:0]));
                end
            end
            done_prev = o_done;
        end
    end

    task automatic run_test(input int d_ch, input bit inv, input bit flips,
                            input int n, input bit chk_en, input bit mid_start);
        int  g, dsel, r0, errs, bits, end_t, cyc;
        bit  ok, bad;
        g = tick_idx;
        cur_d = d_ch; cur_inv = inv; flip_en = 1'b0;
        ok = 1'b0; dsel = 0;
        for (int d = 0; d < 8 && !ok; d++) begin
            bad = 1'b0;
            for (int j = 0; j < 16; j++)
                if (rx_at(g + d*16 + j, 1'b0) != ref_at(g + d*16 + j, d)) bad = 1'b1;
            if (!bad) begin ok = 1'b1; dsel = d; end
        end
        errs = 0; bits = 0;
        if (ok) begin
            r0 = g + (dsel + 1) * 16;
            flip_en = flips; flip_a = r0 + 10; flip_b = r0 + 57;
            for (int k = r0; k < r0 + n; k++)
                if (rx_at(k, 1'b1) != ref_at(k, dsel)) errs++;
            bits = n; end_t = r0 + n;
        end else begin
            end_t = g + 128;
        end
        exp_q.push_back({ok, 3'(dsel), 16'(bits), 16'(errs), 16'(end_t)});

        i_n_symbols = NS'(n);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        i_n_symbols = NS'($urandom_range(0, 65535));
        chk("busy_after_start", int'(o_busy), 1);
        if (chk_en) begin
            for (int c = 1; c <= 12; c++) begin
                chk($sformatf("enable_c%0d", c), int'(o_enable), int'(c % 4 == 0));
                @(negedge i_clk);
            end
        end
        if (mid_start) begin
            cyc = 0;
            while (o_bit_count < 20 && cyc < 2000) begin @(negedge i_clk); cyc++; end
            i_start = 1'b1; i_n_symbols = NS'(5);
            @(negedge i_clk);
            i_start = 1'b0;
        end
        cyc = 0;
        while (!o_done && cyc < 3000) begin @(negedge i_clk); cyc++; end
        if (!o_done) chk("done_timeout", 0, 1);
        @(negedge i_clk);
    endtask

    initial begin
        logic [8:0] lfsr;
        int bad, cyc;
        lfsr = 9'h1FF;
        for (int i = 0; i < 8192; i++) begin
            ref_seq[i] = lfsr[8] ^ lfsr[4];
            lfsr = {lfsr[7:0], lfsr[8] ^ lfsr[4]};
        end

        repeat (3) @(negedge i_clk);
        #1 i_reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge i_clk);
            if (o_enable || o_busy || o_done || o_sync_ok || o_delay != 0 ||
                o_bit_count != 0 || o_err_count != 0) bad++;
        end
        chk("idle_quiet_cycles", bad, 0);
        chk("reset_done", int'(o_done), 0);
        chk("reset_bits", int'(o_bit_count), 0);

        // Delay-3 channel with enable-timing checks.
        run_test(3, 1'b0, 1'b0, 100, 1'b1, 1'b0);
        chk("d3_delay", int'(o_delay), 3);
        chk("d3_bits", int'(o_bit_count), 100);
        chk("d3_errs", int'(o_err_count), 0);
        chk("d3_sync", int'(o_sync_ok), 1);

        // Same with two injected errors in RUN.
        run_test(3, 1'b0, 1'b1, 100, 1'b0, 1'b0);
        chk("flip_errs", int'(o_err_count), 2);

        // Inverted channel cannot lock.
        run_test(0, 1'b1, 1'b0, 50, 1'b0, 1'b0);
        chk("inv_sync", int'(o_sync_ok), 0);
        chk("inv_bits", int'(o_bit_count), 0);

        // Ignored start in RUN, then zero-length run.
        run_test(1, 1'b0, 1'b0, 60, 1'b0, 1'b1);
        chk("mid_start_bits", int'(o_bit_count), 60);
        run_test(0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

        for (int t = 0; t < 6; t++)
            run_test($urandom_range(0, 7), 1'b0, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 120), 1'b0, 1'b0);

        // Reset mid-RUN.
        i_n_symbols = NS'(200);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        cyc = 0;
        while (o_bit_count < 6 && cyc < 2000) begin @(negedge i_clk); cyc++; end
        chk("reached_run", int'(o_bit_count >= 6), 1);
        i_reset = 1'b1;
        #1;
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_enable", int'(o_enable), 0);
        chk("rst_sync", int'(o_sync_ok), 0);
        chk("rst_bits", int'(o_bit_count), 0);
        chk("rst_delay", int'(o_delay), 0);
        @(negedge i_clk);
        #1 i_reset = 1'b0;
        exp_q.delete();
        repeat (8) @(negedge i_clk);
        chk("post_rst_idle", int'(o_busy | o_done | o_enable), 0);

        run_test(2, 1'b0, 1'b0, 30, 1'b0, 1'b0);
        chk("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
